// File: rtl/fifo_reader.sv
// Read-side controller for a fall-through FIFO: pops len*col entries per command and
// packs each group of col entries into one wide word on a valid/ready output stream.
module fifo_reader #(
    parameter int bw     = 8,
    parameter int col    = 8,
    parameter int cnt_bw = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_empty,
    input  logic [bw-1:0]         i_data,
    output logic                  o_rd,
    input  logic                  start,
    input  logic [cnt_bw-1:0]     len,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [col*bw-1:0]     out_data,
    output logic                  busy,
    output logic                  done,
    output logic [1:0]            dbg_state
);

    // Output stream: a word transfers on any rising edge where out_valid & out_ready.
    // out_valid, once raised, stays up with out_data frozen until that transfer.

    localparam int lw = (col > 2) ? $clog2(col) : 1;
    localparam logic [lw-1:0] last_lane = lw'(col - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [lw-1:0]           lane;
    logic [cnt_bw-1:0]       word_cnt;
    logic [cnt_bw-1:0]       len_q;
    logic [(col-1)*bw-1:0]   part;
    logic                    stall;
    logic                    pop;
    logic                    pop_last;
    logic                    last_word;

    // The top lane cannot be popped while the previous word is still waiting,
    // because that pop overwrites out_data.
    assign stall     = (lane == last_lane) && out_valid && !out_ready;
    assign pop       = (state == READ) && !i_empty && !stall && !reset;
    assign pop_last  = pop && (lane == last_lane);
    assign last_word = (word_cnt + cnt_bw'(1)) == len_q;

    assign o_rd      = pop;
    assign busy      = (state == READ) || (state == FLUSH);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                if (pop_last && last_word) begin
                    state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                if (out_valid && out_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lane      <= '0;
            word_cnt  <= '0;
            len_q     <= '0;
            part      <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                len_q    <= len;
                word_cnt <= '0;
                lane     <= '0;
            end
            if (pop) begin
                if (pop_last) begin
                    out_data <= {i_data, part};
                    lane     <= '0;
                    word_cnt <= word_cnt + cnt_bw'(1);
                end else begin
                    for (int k = 0; k < col - 1; k++) begin
                        if (lane == lw'(k)) begin
                            part[k*bw +: bw] <= i_data;
                        end
                    end
                    lane <= lane + lw'(1);
                end
            end
            // A word loaded on the accept edge keeps out_valid high: full-rate streaming.
            if (pop_last) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Bench for fifo_reader (col=4, bw=8): array-backed FIFO, expected-word queue built
// from the FIFO contents, one negedge compare process, directed and random commands.
module tb_fifo_reader;

    localparam int bw     = 8;
    localparam int col    = 4;
    localparam int cnt_bw = 8;
    localparam int W      = col * bw;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              i_empty;
    logic [bw-1:0]     i_data;
    logic              o_rd;
    logic              start = 1'b0;
    logic [cnt_bw-1:0] len = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [W-1:0]      out_data;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    fifo_reader #(.bw(bw), .col(col), .cnt_bw(cnt_bw)) dut (
        .clk(clk), .reset(reset), .i_empty(i_empty), .i_data(i_data), .o_rd(o_rd),
        .start(start), .len(len), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // ---------------- FIFO model (contents known up front, wr_ptr releases them)
    logic [bw-1:0] mem [0:1023];
    int rd_ptr = 0;
    int wr_ptr = 0;
    assign i_empty = (rd_ptr == wr_ptr);
    assign i_data  = mem[rd_ptr[9:0]];
    always @(posedge clk) if (o_rd && !i_empty) rd_ptr <= rd_ptr + 1;

    // ---------------- scoreboard state
    logic [W-1:0] exp_q[$];
    int model_rd = 0;
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int pops = 0;
    int done_seen = 0;
    int last_acc_cyc = 0;
    int done_cyc = 0;
    int ready_pct = 100;
    bit done_allowed = 1'b0;
    bit hold_enable = 1'b0;
    bit hold_used = 1'b0;
    int hold_cnt = 0;
    bit hold_last = 1'b0;
    int hold_base = 0;
    bit prev_held = 1'b0;
    logic [W-1:0] prev_data = '0;

    task automatic check(input bit ok, input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [W-1:0] pack(input int base);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < col; k++) w[k*bw +: bw] = mem[(base + k) % 1024];
        return w;
    endfunction

    // ---------------- compare process: drives out_ready, checks every cycle
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (hold_enable && !hold_used && out_valid) begin
            hold_cnt  = 5;
            hold_used = 1'b1;
        end
        if (hold_cnt > 0) begin
            out_ready = 1'b0;
            hold_cnt--;
            hold_last = (hold_cnt == 0);
        end else begin
            out_ready = ($urandom_range(99) < ready_pct);
            hold_last = 1'b0;
        end
        #1;
        if (reset) begin
            check(!o_rd, "rd_in_reset", W'(o_rd), 0);
        end else begin
            check(!(o_rd && i_empty), "rd_when_empty", W'(o_rd), 0);
            if (prev_held) check(out_valid && out_data == prev_data, "hold_stable", out_data, prev_data);
            if (o_rd) pops++;
            if (out_valid && out_ready) begin
                last_acc_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check(1'b0, "unexpected_word", out_data, 0);
                end else begin
                    e = exp_q.pop_front();
                    check(out_data == e, "word", out_data, e);
                end
            end
            if (done) begin
                check(done_allowed, "done_expected", W'(done), W'(done_allowed));
                check(!busy, "busy_low_at_done", W'(busy), 0);
                done_seen++;
                done_cyc = cyc;
            end
            if (hold_last) begin
                check((pops - hold_base) == 7 && !o_rd, "stall_pop_count", W'(pops - hold_base), 7);
                check(out_data == 32'h04030201, "stall_data", out_data, 32'h04030201);
            end
        end
        prev_held = !reset && out_valid && !out_ready;
        prev_data = out_data;
    end

    // ---------------- driver tasks
    task automatic send_start(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = n[cnt_bw-1:0];
        @(negedge clk);
        start = 1'b0;
        len   = '0;
    endtask

    task automatic push_n(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            repeat (gap) @(negedge clk);
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic wait_done(input int d0);
        int i;
        i = 0;
        while (done_seen == d0 && i < 3000) begin
            @(negedge clk);
            #2;
            i++;
        end
        check(done_seen == d0 + 1, "done_count", W'(done_seen - d0), 1);
    endtask

    task automatic run_cmd(input int n, input bit extra_start);
        int p0;
        int d0;
        for (int w = 0; w < n; w++) exp_q.push_back(pack(model_rd + w * col));
        model_rd     = model_rd + n * col;
        p0           = pops;
        d0           = done_seen;
        done_allowed = 1'b1;
        send_start(n);
        if (n == 0) begin
            #2;
            check(done, "len0_done_latency", W'(done), 1);
        end else if (extra_start) begin
            repeat (2) @(negedge clk);
            start = 1'b1;
            len   = 8'd7;
            @(negedge clk);
            start = 1'b0;
            len   = '0;
        end
        wait_done(d0);
        if (n > 0) check(done_cyc == last_acc_cyc + 1, "done_after_accept", W'(done_cyc - last_acc_cyc), 1);
        check(exp_q.size() == 0, "words_left", W'(exp_q.size()), 0);
        @(negedge clk);
        #2;
        check((pops - p0) == n * col, "pop_total", W'(pops - p0), W'(n * col));
        check(!busy && !done, "idle_after_done", {busy, done}, 0);
        done_allowed = 1'b0;
    endtask

    // ---------------- main sequence
    initial begin
        int p0;
        int d0;
        int base;
        int i;
        int n;
        for (int k = 0; k < 1024; k++) mem[k] = bw'($urandom);
        for (int k = 0; k < 8; k++) mem[k] = bw'(k + 1);
        for (int k = 0; k < 8; k++) mem[8 + k] = bw'(k + 1);

        repeat (2) @(negedge clk);
        #2;
        check(!o_rd && !out_valid && !busy && !done, "reset_flags", {o_rd, out_valid, busy, done}, 0);
        check(out_data == '0, "reset_data", out_data, 0);
        check(dbg_state == 2'd0, "reset_state", W'(dbg_state), 0);
        reset = 1'b0;

        // Preloaded 0x01..0x08, always ready, len=2.
        wr_ptr = 8;
        exp_q.push_back(pack(0));
        exp_q.push_back(pack(4));
        check(exp_q[0] == 32'h04030201, "model_word0", exp_q[0], 32'h04030201);
        check(exp_q[1] == 32'h08070605, "model_word1", exp_q[1], 32'h08070605);
        model_rd     = 8;
        p0           = pops;
        d0           = done_seen;
        done_allowed = 1'b1;
        send_start(2);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            #2;
            check(o_rd, "consecutive_rd", W'(o_rd), 1);
            if (k == 0) check(busy, "busy_after_start", W'(busy), 1);
            if (k == 3) check(!out_valid, "valid_not_early", W'(out_valid), 0);
            if (k == 4) check(out_valid, "first_valid_latency", W'(out_valid), 1);
        end
        wait_done(d0);
        check(done_cyc == last_acc_cyc + 1, "done_after_accept", W'(done_cyc - last_acc_cyc), 1);
        @(negedge clk);
        #2;
        check((pops - p0) == 8, "pop_total", W'(pops - p0), 8);
        check(!busy, "busy_low_after", W'(busy), 0);
        done_allowed = 1'b0;

        // Same data, out_ready held low for 5 cycles once the first word appears.
        wr_ptr      = 16;
        hold_base   = pops;
        hold_enable = 1'b1;
        run_cmd(2, 1'b0);

        // FIFO starts empty, one entry every 3 cycles.
        fork push_n(3 * col, 3); join_none
        run_cmd(3, 1'b0);

        // len=0: no pops, immediate done.
        run_cmd(0, 1'b0);

        // Reset after 3 pops of a len=2 command.
        base = model_rd;
        wr_ptr = wr_ptr + 8;
        send_start(2);
        i = 0;
        while (rd_ptr - base < 3 && i < 200) begin
            @(negedge clk);
            i++;
        end
        check(rd_ptr - base == 3, "reset_point_reached", W'(rd_ptr - base), 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #2;
        check(!out_valid && !busy && !done, "after_reset", {out_valid, busy, done}, 0);
        check(rd_ptr == base + 3, "no_pop_on_reset", W'(rd_ptr - base), 3);
        model_rd = base + 3;
        exp_q.delete();
        repeat (3) @(negedge clk);
        run_cmd(1, 1'b0);

        // Random commands, random ready, trickled FIFO, stray start while busy.
        for (int c = 0; c < 8; c++) begin
            n = $urandom_range(1, 5);
            ready_pct = $urandom_range(30, 100);
            fork push_n(n * col, $urandom_range(0, 2)); join_none
            run_cmd(n, 1'b1);
        end
        ready_pct = 100;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
